// File: rtl/mem_access_stage_if.sv
// Bundle of the memory-access stage's upstream, downstream and data-memory signals.
// The stage uses the slave modport; the surrounding pipeline or bench drives the master side.
interface mem_access_stage_if #(
   parameter int ADDR_W = 32,
   parameter int RD_W   = 5
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_alures;
   logic [31:0]       in_busb;
   logic [31:0]       in_PC;
   logic [RD_W-1:0]   in_rd;
   logic [2:0]        in_MemOp;
   logic              in_MemWr;
   logic              in_MemtoReg;
   logic              in_RegWr;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_wdata;
   logic [RD_W-1:0]   out_rd;
   logic              out_RegWr;
   logic [31:0]       out_PC;
   logic              out_misalign;
   logic              dmem_req;
   logic              dmem_ready;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [31:0]       dmem_wdata;
   logic [3:0]        dmem_wmask;
   logic              dmem_rvalid;
   logic [31:0]       dmem_rdata;

   modport slave (
      input  flush, in_valid, in_alures, in_busb, in_PC, in_rd, in_MemOp,
             in_MemWr, in_MemtoReg, in_RegWr, out_ready,
             dmem_ready, dmem_rvalid, dmem_rdata,
      output in_ready, out_valid, out_wdata, out_rd, out_RegWr, out_PC,
             out_misalign, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask
   );

   modport master (
      output flush, in_valid, in_alures, in_busb, in_PC, in_rd, in_MemOp,
             in_MemWr, in_MemtoReg, in_RegWr, out_ready,
             dmem_ready, dmem_rvalid, dmem_rdata,
      input  in_ready, out_valid, out_wdata, out_rd, out_RegWr, out_PC,
             out_misalign, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask
   );
endinterface

// File: rtl/mem_access_stage.sv
// RV32 memory-access pipeline stage: issues loads/stores on a req/ready data port,
// extends load data and forwards the write-back value with valid/ready handshakes.
module mem_access_stage #(
   parameter int ADDR_W = 32,
   parameter int RD_W   = 5
) (
   input logic             clk,
   input logic             rst,
   mem_access_stage_if.slave bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   logic [2:0]      r_state;
   logic [2:0]      w_next_state;
   logic [31:0]     r_addr;
   logic [31:0]     r_busb;
   logic [31:0]     r_pc;
   logic [31:0]     r_result;
   logic [RD_W-1:0] r_rd;
   logic [2:0]      r_memop;
   logic            r_memwr;
   logic            r_regwr;
   logic            r_misalign;

   logic            w_in_ready;
   logic            w_accept;
   logic            w_in_misalign;
   logic [2:0]      w_entry_state;
   logic            w_req;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [31:0]     w_load_data;
   logic [31:0]     w_store_data;
   logic [3:0]      w_store_mask;

   assign w_in_ready = !bus.flush && ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready));
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_req      = (r_state == S_REQ);

   // Alignment only matters for real memory accesses; ALU results pass through untouched.
   assign w_in_misalign = (bus.in_MemtoReg || bus.in_MemWr) &&
                          (((bus.in_MemOp[1:0] == 2'b01) && bus.in_alures[0]) ||
                           ((bus.in_MemOp[1:0] == 2'b10) && (bus.in_alures[1:0] != 2'b00)));

   assign w_entry_state = w_in_misalign                      ? S_DONE :
                          (bus.in_MemWr || bus.in_MemtoReg)  ? S_REQ  : S_DONE;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_byte = bus.dmem_rdata[7:0];
      case (r_addr[1:0])
         2'b01:   w_byte = bus.dmem_rdata[15:8];
         2'b10:   w_byte = bus.dmem_rdata[23:16];
         2'b11:   w_byte = bus.dmem_rdata[31:24];
         default: w_byte = bus.dmem_rdata[7:0];
      endcase
      w_half = r_addr[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
      case (r_memop)
         3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
         3'b100:  w_load_data = {24'd0, w_byte};
         3'b101:  w_load_data = {16'd0, w_half};
         default: w_load_data = bus.dmem_rdata;
      endcase
   end

   always_comb begin
      w_store_data = r_busb;
      w_store_mask = 4'b1111;
      case (r_memop[1:0])
         2'b00: begin
            w_store_data = {4{r_busb[7:0]}};
            w_store_mask = 4'b0001 << r_addr[1:0];
         end
         2'b01: begin
            w_store_data = {2{r_busb[15:0]}};
            w_store_mask = r_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            w_store_data = r_busb;
            w_store_mask = 4'b1111;
         end
      endcase
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next_state = w_entry_state;
         S_REQ: begin
            if (bus.dmem_ready) begin
               if (r_memwr) w_next_state = bus.flush ? S_IDLE : S_DONE;
               else         w_next_state = bus.flush ? S_DRAIN : S_WAIT;
            end else if (bus.flush) begin
               w_next_state = S_IDLE;
            end
         end
         // A response arriving with the flush is itself the one being discarded.
         S_WAIT: begin
            if (bus.flush)            w_next_state = bus.dmem_rvalid ? S_IDLE : S_DRAIN;
            else if (bus.dmem_rvalid) w_next_state = S_DONE;
         end
         S_DONE: begin
            if (bus.flush)          w_next_state = S_IDLE;
            else if (bus.out_ready) w_next_state = w_accept ? w_entry_state : S_IDLE;
         end
         S_DRAIN: if (bus.dmem_rvalid) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_busb     <= '0;
         r_pc       <= '0;
         r_result   <= '0;
         r_rd       <= '0;
         r_memop    <= '0;
         r_memwr    <= 1'b0;
         r_regwr    <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_addr     <= bus.in_alures;
            r_busb     <= bus.in_busb;
            r_pc       <= bus.in_PC;
            r_result   <= bus.in_alures;
            r_rd       <= bus.in_rd;
            r_memop    <= bus.in_MemOp;
            r_memwr    <= bus.in_MemWr;
            r_regwr    <= bus.in_RegWr && !w_in_misalign;
            r_misalign <= w_in_misalign;
         end else if ((r_state == S_WAIT) && !bus.flush && bus.dmem_rvalid) begin
            r_result <= w_load_data;
         end
      end
   end

   assign bus.in_ready     = w_in_ready;
   assign bus.out_valid    = (r_state == S_DONE);
   assign bus.out_wdata    = r_result;
   assign bus.out_rd       = r_rd;
   assign bus.out_RegWr    = r_regwr;
   assign bus.out_PC       = r_pc;
   assign bus.out_misalign = r_misalign;

   assign bus.dmem_req   = w_req;
   assign bus.dmem_we    = w_req && r_memwr;
   assign bus.dmem_addr  = w_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
   assign bus.dmem_wdata = (w_req && r_memwr) ? w_store_data : '0;
   assign bus.dmem_wmask = (w_req && r_memwr) ? w_store_mask : '0;

endmodule
